wm8731_i2c_config: RTL and testbench
====================================

// Module: wm8731_i2c_config
// PURPOSE
//  Power-up configuration sequencer for the WM8731 audio codec over I2C.
//  Walks a fixed table of codec register writes, emits each as a 3-byte I2C write
//  (addr+W, {reg[6:0],data[8]}, data[7:0]), checks ACKs and retries on NACK.
//  Sits beside the audio core and drives the codec I2C pins in place of the soft-CPU PIOs.
//  Raises done once the codec is configured, so the audio datapath can be released.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency
//  I2C_HZ      100000    SCL frequency; quarter-bit tick every CLK_HZ/(4*I2C_HZ) clocks (125 at defaults)
//  DEV_ADDR    7'h1A     codec 7-bit slave address (CSB=0) -> first byte 0x34
//  MAX_RETRY   3         attempts per register before error
//  AUTO_START  1         1: run the table once after reset without a start pulse
// PORTS
//  clk      in   1   system clock
//  reset    in   1   synchronous, active-high reset
//  start    in   1   1-cycle pulse: (re)run the whole table; ignored while busy
//  sda_i    in   1   sampled SDA pin level
//  sda_oe   out  1   1 = pull SDA low, 0 = release (open-drain; top level ties pin to 1'bz/0)
//  scl_o    out  1   SCL level (push-pull, no clock stretching)
//  busy     out  1   sequence in progress
//  done     out  1   table completed with all ACKs; held until next start/reset
//  error    out  1   some register NACKed MAX_RETRY times; held until next start/reset
//  err_idx  out  4   table index of the failing register (valid while error=1)
// BEHAVIOUR
//  - Reset: sda_oe=0, scl_o=1, busy=0, done=0, error=0, err_idx=0, tick counter=0,
//    idx=0, retry=0; FSM -> IDLE. Reset mid-transfer releases the bus on the next clock
//    (no STOP generated). If AUTO_START=1, leave IDLE on the first cycle after reset deasserts.
//  - Table (idx 0..9, {reg,data9}): R15=0x000 (reset), R0=0x017, R1=0x017, R2=0x079,
//    R3=0x079, R4=0x012, R5=0x000, R6=0x000, R7=0x042, R9=0x001 (active, written last).
//  - Timing: all bus changes occur only on tick (1-cycle strobe, div counter reloads).
//    Each bit = 4 ticks, q0: SCL low, change SDA; q1: SCL high; q2: sample sda_i; q3: SCL low.
//  - FSM: IDLE -> START (SDA falls while SCL high, 2 ticks) -> BYTE (8 bits MSB-first)
//    -> ACK (release SDA, sample at q2) -> BYTE for the next byte, or STOP after byte 3
//    -> GAP (16 ticks bus free) -> NEXT.
//    NEXT: idx==9 -> DONE; else idx++, retry=0, -> START.
//  - ACK low: continue. ACK high (NACK): -> STOP immediately, then GAP, retry++.
//    If retry < MAX_RETRY, resend the same idx from byte 1. Otherwise -> ERR:
//    error=1, err_idx=idx.
//  - DONE/ERR: bus released (scl_o=1, sda_oe=0), busy=0. start -> clear flags, idx=0, -> START.
//  - busy=1 from the cycle after leaving IDLE/DONE/ERR until entering DONE/ERR.
//  - start during busy has no effect. done and error are never both 1.
//  - SDA changes only while SCL is low, except for START and STOP conditions.
// TESTING
//  1. Reset, AUTO_START=1, ACK-always slave model -> 10 transactions; first bytes 0x34,0x1E,0x00;
//     last bytes 0x34,0x12,0x01; then done=1, busy=0.
//  2. Measure SCL -> period 500 clocks (10 us); SDA never toggles while SCL high,
//     except at START/STOP edges.
//  3. Slave NACKs idx 3 once -> STOP, idx 3 resent once, sequence completes with done=1.
//  4. Slave always NACKs idx 5 -> exactly 3 attempts, error=1, err_idx=5, done=0,
//     bus released, busy=0.
//  5. Assert reset during byte 2 of idx 4 -> next clock sda_oe=0, scl_o=1, busy=0;
//     sequence restarts at idx 0.
//  6. After done, pulse start twice (second pulse while busy) -> exactly one extra
//     full 10-write pass.

Source files
------------

// File: rtl/wm8731_i2c_config.sv
// WM8731 power-up configuration sequencer: walks a fixed register table and
// issues each entry as a 3-byte I2C write, retrying on NACK.
module wm8731_i2c_config #(
   parameter int         CLK_HZ     = 50000000,
   parameter int         I2C_HZ     = 100000,
   parameter logic [6:0] DEV_ADDR   = 7'h1A,
   parameter int         MAX_RETRY  = 3,
   parameter int         AUTO_START = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       scl_o,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] err_idx
);

   localparam int            DIV       = CLK_HZ / (4 * I2C_HZ);
   localparam int            DW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [7:0]    RETRY_LIM = 8'(MAX_RETRY);
   localparam logic [3:0]    LAST_IDX  = 4'd9;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [1:0]    q;
   logic [2:0]    bit_cnt;
   logic [1:0]    byte_cnt;
   logic [3:0]    gap_cnt;
   logic [7:0]    sh;
   logic [3:0]    idx;
   logic [7:0]    retry;
   logic          nack;

   // {reg[6:0], data[8:0]}; R9 (active) goes last so the codec only runs once configured
   function automatic logic [15:0] cfg_word(input logic [3:0] i);
      case (i)
         4'd0:    cfg_word = {7'd15, 9'h000};
         4'd1:    cfg_word = {7'd0,  9'h017};
         4'd2:    cfg_word = {7'd1,  9'h017};
         4'd3:    cfg_word = {7'd2,  9'h079};
         4'd4:    cfg_word = {7'd3,  9'h079};
         4'd5:    cfg_word = {7'd4,  9'h012};
         4'd6:    cfg_word = {7'd5,  9'h000};
         4'd7:    cfg_word = {7'd6,  9'h000};
         4'd8:    cfg_word = {7'd7,  9'h042};
         4'd9:    cfg_word = {7'd9,  9'h001};
         default: cfg_word = 16'h0000;
      endcase
   endfunction

   function automatic logic [7:0] tx_byte(input logic [3:0] i, input logic [1:0] sel);
      logic [15:0] w;
      w = cfg_word(i);
      case (sel)
         2'd0:    tx_byte = {DEV_ADDR, 1'b0};
         2'd1:    tx_byte = w[15:8];
         default: tx_byte = w[7:0];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DW'(1);
         tick    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         sda_oe   <= 1'b0;
         scl_o    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_idx  <= 4'd0;
         idx      <= 4'd0;
         retry    <= 8'd0;
         q        <= 2'd0;
         bit_cnt  <= 3'd0;
         byte_cnt <= 2'd0;
         gap_cnt  <= 4'd0;
         sh       <= 8'd0;
         nack     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (AUTO_START != 0 || start) begin
                  busy  <= 1'b1;
                  idx   <= 4'd0;
                  retry <= 8'd0;
                  q     <= 2'd0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (tick) begin
                  if (q == 2'd0) begin
                     sda_oe <= 1'b1;
                     q      <= 2'd1;
                  end else begin
                     scl_o    <= 1'b0;
                     q        <= 2'd0;
                     bit_cnt  <= 3'd7;
                     byte_cnt <= 2'd0;
                     sh       <= tx_byte(idx, 2'd0);
                     nack     <= 1'b0;
                     state    <= S_BYTE;
                  end
               end
            end
            // q0 drive SDA, q1 SCL high, q2 slave samples, q3 SCL low
            S_BYTE: begin
               if (tick) begin
                  q <= q + 2'd1;
                  case (q)
                     2'd0: sda_oe <= ~sh[7];
                     2'd1: scl_o  <= 1'b1;
                     2'd3: begin
                        scl_o <= 1'b0;
                        sh    <= {sh[6:0], 1'b0};
                        if (bit_cnt == 3'd0) state <= S_ACK;
                        else bit_cnt <= bit_cnt - 3'd1;
                     end
                     default: ;
                  endcase
               end
            end
            S_ACK: begin
               if (tick) begin
                  q <= q + 2'd1;
                  case (q)
                     2'd0: sda_oe <= 1'b0;
                     2'd1: scl_o  <= 1'b1;
                     2'd2: nack   <= sda_i;
                     default: begin
                        scl_o <= 1'b0;
                        if (nack || byte_cnt == 2'd2) begin
                           state <= S_STOP;
                        end else begin
                           byte_cnt <= byte_cnt + 2'd1;
                           bit_cnt  <= 3'd7;
                           sh       <= tx_byte(idx, byte_cnt + 2'd1);
                           state    <= S_BYTE;
                        end
                     end
                  endcase
               end
            end
            // SDA low under low SCL, raise SCL, then release SDA while SCL is high
            S_STOP: begin
               if (tick) begin
                  case (q)
                     2'd0: begin
                        sda_oe <= 1'b1;
                        q      <= 2'd1;
                     end
                     2'd1: begin
                        scl_o <= 1'b1;
                        q     <= 2'd2;
                     end
                     default: begin
                        sda_oe  <= 1'b0;
                        q       <= 2'd0;
                        gap_cnt <= 4'd0;
                        state   <= S_GAP;
                     end
                  endcase
               end
            end
            S_GAP: begin
               if (tick) begin
                  gap_cnt <= gap_cnt + 4'd1;
                  if (gap_cnt == 4'd15) state <= S_NEXT;
               end
            end
            S_NEXT: begin
               q <= 2'd0;
               if (nack) begin
                  if ((retry + 8'd1) < RETRY_LIM) begin
                     retry <= retry + 8'd1;
                     state <= S_START;
                  end else begin
                     error   <= 1'b1;
                     err_idx <= idx;
                     busy    <= 1'b0;
                     state   <= S_ERR;
                  end
               end else if (idx == LAST_IDX) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  retry <= 8'd0;
                  state <= S_START;
               end
            end
            default: begin
               if (start) begin
                  done  <= 1'b0;
                  error <= 1'b0;
                  idx   <= 4'd0;
                  retry <= 8'd0;
                  q     <= 2'd0;
                  busy  <= 1'b1;
                  state <= S_START;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wm8731_i2c_config.sv
// Directed bench for wm8731_i2c_config: an I2C slave model captures each write,
// ACKs or NACKs on demand, and tracks SCL timing and START/STOP conditions.
module tb_wm8731_i2c_config;

   localparam int TB_CLK_HZ = 800000;
   localparam int TB_I2C_HZ = 100000;
   localparam int SCL_PER   = 4 * (TB_CLK_HZ / (4 * TB_I2C_HZ));

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       sda_i;
   logic       sda_oe;
   logic       scl_o;
   logic       busy;
   logic       done;
   logic       error;
   logic [3:0] err_idx;
   logic       slave_pull = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] trans[$];
   int          n_start = 0;
   int          n_stop = 0;
   int          n_per_ok = 0;
   int          n_per_bad = 0;
   int          nack_used = 0;
   int          nack_limit = 0;
   logic [7:0]  nack_byte = 8'hFF;
   int          s_bitcnt = 0;
   int          s_bytecnt = 0;
   bit          in_ack = 1'b0;
   logic [7:0]  s_sh = 8'h00;
   logic [7:0]  cur [3];
   int          cyc = 0;
   int          last_rise = -1;
   logic        scl_prev = 1'b1;
   logic        sda_prev = 1'b1;
   logic        sda_now;

   logic [23:0] exp_tab [10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                                 24'h340812, 24'h340A00, 24'h340C00, 24'h340E42, 24'h341201};

   assign sda_i = ~(sda_oe | slave_pull);

   always #5 clk = ~clk;

   wm8731_i2c_config #(
      .CLK_HZ(TB_CLK_HZ),
      .I2C_HZ(TB_I2C_HZ),
      .DEV_ADDR(7'h1A),
      .MAX_RETRY(3),
      .AUTO_START(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .sda_i(sda_i),
      .sda_oe(sda_oe),
      .scl_o(scl_o),
      .busy(busy),
      .done(done),
      .error(error),
      .err_idx(err_idx)
   );

   // Slave model and bus monitor, sampled on the falling clock edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         sda_now = ~(sda_oe | slave_pull);
         if (scl_prev === 1'b1 && scl_o === 1'b1 && sda_prev === 1'b1 && sda_now === 1'b0) begin
            n_start++;
            s_bitcnt = 0;
            s_bytecnt = 0;
            in_ack = 1'b0;
            slave_pull = 1'b0;
            last_rise = -1;
         end else if (scl_prev === 1'b1 && scl_o === 1'b1 && sda_prev === 1'b0 && sda_now === 1'b1) begin
            n_stop++;
            if (s_bytecnt == 3) trans.push_back({cur[0], cur[1], cur[2]});
            s_bytecnt = 0;
            s_bitcnt = 0;
         end else if (scl_prev === 1'b0 && scl_o === 1'b1) begin
            if (last_rise >= 0) begin
               if (cyc - last_rise == SCL_PER) n_per_ok++;
               else n_per_bad++;
            end
            last_rise = cyc;
            if (!in_ack && s_bitcnt < 8) begin
               s_sh = {s_sh[6:0], sda_now};
               s_bitcnt++;
            end
         end else if (scl_prev === 1'b1 && scl_o === 1'b0) begin
            if (in_ack) begin
               in_ack = 1'b0;
               slave_pull = 1'b0;
               s_bitcnt = 0;
               s_bytecnt++;
            end else if (s_bitcnt == 8) begin
               in_ack = 1'b1;
               if (s_bytecnt < 3) cur[s_bytecnt] = s_sh;
               if (s_bytecnt == 0 && s_sh != 8'h34) begin
                  slave_pull = 1'b0;
               end else if (s_bytecnt == 1 && s_sh == nack_byte && nack_used < nack_limit) begin
                  slave_pull = 1'b0;
                  nack_used++;
               end else begin
                  slave_pull = 1'b1;
               end
            end
         end
         scl_prev = scl_o;
         sda_prev = ~(sda_oe | slave_pull);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit ok);
      int i;
      i = 0;
      while (!(done === 1'b1 || error === 1'b1) && i < budget) begin
         @(negedge clk);
         i++;
      end
      ok = (done === 1'b1 || error === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      n_checks++; if (scl_o !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", scl_o); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
      n_checks++; if (err_idx !== 4'd0) begin n_fail++; $display("FAIL reset_err_idx: got %0d expected 0", err_idx); end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL auto_start_busy: got %b expected 1", busy); end
   endtask

   task automatic test_auto_sequence();
      int base;
      bit ok;
      base = trans.size();
      wait_end(8000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL seq_timeout: got no done expected done within 8000 cycles"); end
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL seq_done: got %b expected 1", done); end
      n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL seq_error: got %b expected 0", error); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy: got %b expected 0", busy); end
      n_checks++; if (scl_o !== 1'b1 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL seq_bus_idle: got scl=%b sda_oe=%b expected 1/0", scl_o, sda_oe); end
      n_checks++; if (trans.size() - base != 10) begin n_fail++; $display("FAIL seq_count: got %0d expected 10", trans.size() - base); end
      for (int i = 0; i < 10; i++) begin
         if (base + i < trans.size()) begin
            n_checks++;
            if (trans[base + i] !== exp_tab[i]) begin n_fail++; $display("FAIL seq_write%0d: got %h expected %h", i, trans[base + i], exp_tab[i]); end
         end
      end
   endtask

   task automatic test_scl_timing();
      n_checks++; if (n_per_ok != 270) begin n_fail++; $display("FAIL scl_period_count: got %0d periods of %0d clocks expected 270", n_per_ok, SCL_PER); end
      n_checks++; if (n_per_bad != 0) begin n_fail++; $display("FAIL scl_period_bad: got %0d odd periods expected 0", n_per_bad); end
      n_checks++; if (n_start != 10) begin n_fail++; $display("FAIL sda_high_falls: got %0d expected 10", n_start); end
      n_checks++; if (n_stop != 10) begin n_fail++; $display("FAIL sda_high_rises: got %0d expected 10", n_stop); end
   endtask

   task automatic test_nack_retry();
      int base, sbase, pbase, nbase;
      bit ok;
      base = trans.size();
      sbase = n_start;
      pbase = n_stop;
      nbase = nack_used;
      nack_byte = 8'h04;
      nack_limit = nack_used + 1;
      pulse_start();
      wait_end(8000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL retry_timeout: got no done expected done within 8000 cycles"); end
      n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL retry_flags: got done=%b error=%b expected 1/0", done, error); end
      n_checks++; if (nack_used - nbase != 1) begin n_fail++; $display("FAIL retry_nacks: got %0d expected 1", nack_used - nbase); end
      n_checks++; if (n_start - sbase != 11) begin n_fail++; $display("FAIL retry_starts: got %0d expected 11", n_start - sbase); end
      n_checks++; if (n_stop - pbase != 11) begin n_fail++; $display("FAIL retry_stops: got %0d expected 11", n_stop - pbase); end
      n_checks++; if (trans.size() - base != 10) begin n_fail++; $display("FAIL retry_count: got %0d expected 10", trans.size() - base); end
      n_checks++; if (trans[base + 3] !== exp_tab[3]) begin n_fail++; $display("FAIL retry_idx3: got %h expected %h", trans[base + 3], exp_tab[3]); end
      n_checks++; if (trans[base + 9] !== exp_tab[9]) begin n_fail++; $display("FAIL retry_idx9: got %h expected %h", trans[base + 9], exp_tab[9]); end
      nack_byte = 8'hFF;
   endtask

   task automatic test_nack_error();
      int base, sbase, nbase;
      bit ok;
      base = trans.size();
      sbase = n_start;
      nbase = nack_used;
      nack_byte = 8'h08;
      nack_limit = nack_used + 100;
      pulse_start();
      wait_end(8000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL err_timeout: got no error expected error within 8000 cycles"); end
      n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", error); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL err_done: got %b expected 0", done); end
      n_checks++; if (err_idx !== 4'd5) begin n_fail++; $display("FAIL err_idx: got %0d expected 5", err_idx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy: got %b expected 0", busy); end
      n_checks++; if (scl_o !== 1'b1 || sda_oe !== 1'b0) begin n_fail++; $display("FAIL err_bus_idle: got scl=%b sda_oe=%b expected 1/0", scl_o, sda_oe); end
      n_checks++; if (nack_used - nbase != 3) begin n_fail++; $display("FAIL err_attempts: got %0d expected 3", nack_used - nbase); end
      n_checks++; if (n_start - sbase != 8) begin n_fail++; $display("FAIL err_starts: got %0d expected 8", n_start - sbase); end
      n_checks++; if (trans.size() - base != 5) begin n_fail++; $display("FAIL err_writes: got %0d expected 5", trans.size() - base); end
      nack_byte = 8'hFF;
      nack_limit = nack_used;
   endtask

   task automatic test_reset_midframe();
      int base, base2, i;
      bit ok;
      pulse_start();
      base = trans.size();
      i = 0;
      while (!(trans.size() == base + 4 && s_bytecnt == 1 && s_bitcnt == 3) && i < 8000) begin
         @(negedge clk);
         i++;
      end
      n_checks++; if (i >= 8000) begin n_fail++; $display("FAIL mid_reach: got no byte 2 of idx 4 expected it within 8000 cycles"); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL mid_sda_oe: got %b expected 0", sda_oe); end
      n_checks++; if (scl_o !== 1'b1) begin n_fail++; $display("FAIL mid_scl: got %b expected 1", scl_o); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
      @(negedge clk);
      reset = 1'b0;
      base2 = trans.size();
      n_checks++; if (base2 - base != 4) begin n_fail++; $display("FAIL mid_aborted: got %0d writes expected 4", base2 - base); end
      wait_end(8000, ok);
      n_checks++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b expected 1", done); end
      n_checks++; if (trans.size() - base2 != 10) begin n_fail++; $display("FAIL mid_count: got %0d expected 10", trans.size() - base2); end
      n_checks++; if (trans[base2] !== exp_tab[0]) begin n_fail++; $display("FAIL mid_first: got %h expected %h", trans[base2], exp_tab[0]); end
   endtask

   task automatic test_back_to_back();
      int base, sbase;
      bit ok;
      base = trans.size();
      sbase = n_start;
      pulse_start();
      repeat (20) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      pulse_start();
      wait_end(8000, ok);
      n_checks++; if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
      n_checks++; if (trans.size() - base != 10) begin n_fail++; $display("FAIL b2b_count: got %0d expected 10", trans.size() - base); end
      repeat (600) @(negedge clk);
      n_checks++; if (n_start - sbase != 10) begin n_fail++; $display("FAIL b2b_starts: got %0d expected 10", n_start - sbase); end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got done=%b busy=%b expected 1/0", done, busy); end
   endtask

   initial begin
      test_reset();
      test_auto_sequence();
      test_scl_timing();
      test_nack_retry();
      test_nack_error();
      test_reset_midframe();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
